// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit: FSM states, RV32I
// size/sign funct3 codes, and little-endian lane extract/merge functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  funct3);
        logic [31:0] r;
        r = word;
        case (funct3)
            F3_B, F3_BU: begin
                case (off)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r[7:0]   = wdata[7:0];
                endcase
            end
            F3_H, F3_HU: begin
                if (off[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request legality/alignment check plus load
// extraction and sub-word store merge for the operation in flight.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [1:0]  i_req_off,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    output logic [31:0] o_load,
    output logic [31:0] o_merged,
    output logic        o_req_err
);

    logic w_illegal;
    logic w_misaligned;

    // Unsigned variants exist only for loads
    always_comb begin
        w_illegal = 1'b0;
        case (i_req_funct3)
            F3_B, F3_H, F3_W: w_illegal = 1'b0;
            F3_BU, F3_HU:     w_illegal = i_req_we;
            default:          w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        case (i_req_funct3[1:0])
            2'b01:   w_misaligned = i_req_off[0];
            2'b10:   w_misaligned = (i_req_off != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign o_req_err = w_illegal | w_misaligned;
    assign o_load    = lane_extract(i_mem_word, i_off, i_funct3);
    assign o_merged  = lane_merge(i_mem_word, i_wdata, i_off, i_funct3);

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a single-port word memory with active-low strobes;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    lsu_state_t            r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic [WORDS-1:0]      r_mem_addr;
    logic                  r_done;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_req_err;
    logic                  w_unused_addr;

    // Address bits above the memory size wrap away
    assign w_unused_addr = &{1'b0, addr_i[31:WORDS+2]};

    lsu_align u_align (
        .i_req_we     (we_i),
        .i_req_funct3 (funct3_i),
        .i_req_off    (addr_i[1:0]),
        .i_mem_word   (mem_data_i),
        .i_wdata      (r_wdata),
        .i_funct3     (r_funct3),
        .i_off        (r_off),
        .o_load       (w_load),
        .o_merged     (w_merged),
        .o_req_err    (w_req_err)
    );

    // Request acceptance, RMW sequencing and completion flags
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_wdata    <= {DATA_WIDTH{1'b0}};
            r_rdata    <= {DATA_WIDTH{1'b0}};
            r_mem_data <= {DATA_WIDTH{1'b0}};
            r_mem_addr <= {WORDS{1'b0}};
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        if (w_req_err) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_we       <= we_i;
                            r_funct3   <= funct3_i;
                            r_off      <= addr_i[1:0];
                            r_wdata    <= wdata_i;
                            r_mem_addr <= addr_i[WORDS+1:2];
                            if (we_i && (funct3_i == F3_W)) begin
                                r_mem_data <= wdata_i;
                                r_state    <= WR;
                            end else begin
                                r_state <= RD;
                            end
                        end
                    end
                end
                RD: r_state <= CAP;
                CAP: begin
                    if (r_we) begin
                        r_mem_data <= w_merged;
                        r_state    <= WR;
                    end else begin
                        r_rdata <= w_load;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                WR: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes are blocked while reset is asserted so an aborted RMW never writes
    assign mem_rd_o   = ~((r_state == RD) & ~reset_i);
    assign mem_wr_o   = ~((r_state == WR) & ~reset_i);
    assign ready_o    = (r_state == IDLE);
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign rdata_o    = r_rdata;
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, randomized traffic against a
// word-array reference model, and reset-abort / busy-ignore sequences.
module tb_load_store_unit;
    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wr_o;
    logic        mem_rd_o;
    logic [31:0] mem_data_i;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] model_rd;
    int checks;
    int failures;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
    } vec_t;
    vec_t vt [16];

    load_store_unit #(.WORDS(10), .DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (req),
        .we_i       (we),
        .funct3_i   (f3),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_wr_o   (mem_wr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM: registered read, write on strobe
    always @(posedge clk) begin
        if (!mem_rd_o) mem_data_i <= mem[mem_addr_o];
        if (!mem_wr_o) mem[mem_addr_o] = mem_data_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: size/sign rules applied to a plain word array
    function automatic void model(input logic mwe, input logic [2:0] mf3, input logic [31:0] ma,
                                  input logic [31:0] mwd, output logic eerr, output int elat,
                                  output int nrd, output int nwr);
        int unsigned idx, off, size, sh;
        logic [31:0] w, v, mask;
        bit legal;
        idx  = ma[11:2];
        off  = ma[1:0];
        size = (mf3[1:0] == 2'd0) ? 1 : (mf3[1:0] == 2'd1) ? 2 : 4;
        legal = mwe ? (mf3 <= 3'd2) : (mf3 <= 3'd2 || mf3 == 3'd4 || mf3 == 3'd5);
        eerr = !legal || ((off % size) != 0);
        w  = ref_mem[idx];
        sh = 8 * off;
        if (eerr) begin
            elat = 1; nrd = 0; nwr = 0;
        end else if (!mwe) begin
            v = w >> sh;
            if (size == 1) v = v & 32'hFF;
            else if (size == 2) v = v & 32'hFFFF;
            if (mf3 < 3'd4 && size == 1 && v >= 128) v = v - 256;
            if (mf3 < 3'd4 && size == 2 && v >= 32768) v = v - 65536;
            model_rd = v;
            elat = 3; nrd = 1; nwr = 0;
        end else begin
            mask = (size == 4) ? 32'hFFFFFFFF : (((32'd1 << (8 * size)) - 32'd1) << sh);
            ref_mem[idx] = (w & ~mask) | ((mwd << sh) & mask);
            elat = (size == 4) ? 2 : 4;
            nrd  = (size == 4) ? 0 : 1;
            nwr  = 1;
        end
    endfunction

    task automatic apply(input string tag, input logic awe, input logic [2:0] af3,
                         input logic [31:0] aa, input logic [31:0] awd, input logic xerr,
                         input logic [31:0] xrd, input int xlat, input int xnrd, input int xnwr);
        int lat, nrd, nwr;
        logic e, rdy;
        logic [31:0] rd;
        lat = 0; nrd = 0; nwr = 0; e = 1'bx; rdy = 1'bx; rd = 32'hx;
        we = awe; f3 = af3; addr = aa; wdata = awd; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!mem_rd_o) nrd++;
            if (!mem_wr_o) nwr++;
            if (done_o) begin
                lat = c; e = err_o; rd = rdata_o; rdy = ready_o;
                break;
            end
        end
        check({tag, " latency"}, lat, xlat);
        check({tag, " err"}, {31'd0, e}, {31'd0, xerr});
        check({tag, " rdata"}, rd, xrd);
        check({tag, " ready"}, {31'd0, rdy}, 32'd1);
        check({tag, " rd_pulses"}, nrd, xnrd);
        check({tag, " wr_pulses"}, nwr, xnwr);
    endtask

    task automatic check_memory(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check({tag, " memory_diffs"}, diffs, 32'd0);
    endtask

    task automatic abort_test(input string tag, input logic awe, input logic [2:0] af3,
                              input logic [31:0] aa, input logic [31:0] awd, input int acyc);
        int ndone;
        int idx;
        idx = aa[11:2];
        ndone = 0;
        we = awe; f3 = af3; addr = aa; wdata = awd; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 1; c < acyc; c++) begin
            @(posedge clk);
            #1;
        end
        check({tag, " in_wr"}, {31'd0, mem_wr_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check({tag, " wr_gated"}, {31'd0, mem_wr_o}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        check({tag, " no_done"}, ndone, 32'd0);
        check({tag, " ready"}, {31'd0, ready_o}, 32'd1);
        check({tag, " rdata_reset"}, rdata_o, 32'd0);
        check({tag, " word_kept"}, mem[idx], ref_mem[idx]);
        model_rd = 32'd0;
    endtask

    initial begin
        logic xe;
        int xl, xr, xw, rn, wn;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra, rwd;
        checks = 0; failures = 0; model_rd = 32'd0;
        reset = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom();
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'hCAFEF00D;  ref_mem[1] = 32'hCAFEF00D;
        mem[3] = 32'h55AA3312;  ref_mem[3] = 32'h55AA3312;
        mem[14] = 32'hBBAA1136; ref_mem[14] = 32'hBBAA1136;

        vt[0]  = '{1'b0, 3'b000, 32'h0000000D, 32'h0,        1'b0, 32'h00000033, 3};
        vt[1]  = '{1'b0, 3'b010, 32'h0000000C, 32'h0,        1'b0, 32'h55AA3312, 3};
        vt[2]  = '{1'b0, 3'b101, 32'h0000000E, 32'h0,        1'b0, 32'h000055AA, 3};
        vt[3]  = '{1'b0, 3'b000, 32'h0000003B, 32'h0,        1'b0, 32'hFFFFFFBB, 3};
        vt[4]  = '{1'b0, 3'b100, 32'h0000003B, 32'h0,        1'b0, 32'h000000BB, 3};
        vt[5]  = '{1'b0, 3'b001, 32'h0000003A, 32'h0,        1'b0, 32'hFFFFBBAA, 3};
        vt[6]  = '{1'b1, 3'b000, 32'h00000039, 32'h123456EE, 1'b0, 32'hFFFFBBAA, 4};
        vt[7]  = '{1'b0, 3'b010, 32'h00000038, 32'h0,        1'b0, 32'hBBAAEE36, 3};
        vt[8]  = '{1'b0, 3'b001, 32'h0000000D, 32'h0,        1'b1, 32'hBBAAEE36, 1};
        vt[9]  = '{1'b1, 3'b010, 32'h0000000E, 32'hFFFFFFFF, 1'b1, 32'hBBAAEE36, 1};
        vt[10] = '{1'b0, 3'b011, 32'h0000000C, 32'h0,        1'b1, 32'hBBAAEE36, 1};
        vt[11] = '{1'b0, 3'b010, 32'h00001004, 32'h0,        1'b0, 32'hCAFEF00D, 3};
        vt[12] = '{1'b1, 3'b010, 32'h00001008, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D, 2};
        vt[13] = '{1'b0, 3'b010, 32'h00000008, 32'h0,        1'b0, 32'hDEADBEEF, 3};
        vt[14] = '{1'b1, 3'b001, 32'h0000000A, 32'h0000A5A5, 1'b0, 32'hDEADBEEF, 4};
        vt[15] = '{1'b0, 3'b101, 32'h0000000A, 32'h0,        1'b0, 32'h0000A5A5, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rd_strobe", {31'd0, mem_rd_o}, 32'd1);
        check("reset wr_strobe", {31'd0, mem_wr_o}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("reset ready", {31'd0, ready_o}, 32'd1);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset err", {31'd0, err_o}, 32'd0);
        check("reset rdata", rdata_o, 32'd0);
        check("reset mem_addr", {22'd0, mem_addr_o}, 32'd0);
        check("reset mem_data", mem_data_o, 32'd0);

        for (int i = 0; i < 16; i++) begin
            model(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, xe, xl, xr, xw);
            rn = (vt[i].lat == 3 || vt[i].lat == 4) ? 1 : 0;
            wn = (vt[i].lat == 2 || vt[i].lat == 4) ? 1 : 0;
            apply($sformatf("vec%0d", i), vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd,
                  vt[i].err, vt[i].rd, vt[i].lat, rn, wn);
        end
        check("table word14", mem[14], 32'hBBAAEE36);
        check("table word2", mem[2], 32'hA5A5BEEF);
        check_memory("table");

        // Request presented while busy must be dropped
        we = 1'b1; f3 = 3'b010; addr = 32'h14; wdata = 32'h0BADF00D; req = 1'b1;
        model(1'b1, 3'b010, 32'h14, 32'h0BADF00D, xe, xl, xr, xw);
        @(posedge clk);
        #1 addr = 32'h18; wdata = 32'h12345678;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (4) @(negedge clk);
        check("busy word5", mem[5], 32'h0BADF00D);
        check("busy word6_untouched", mem[6], ref_mem[6]);

        abort_test("abort_sw", 1'b1, 3'b010, 32'h50, 32'h11112222, 1);
        abort_test("abort_sb", 1'b1, 3'b000, 32'h51, 32'h000000AB, 3);

        for (int n = 0; n < 150; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom();
            ra[11:7] = 5'd0;
            rwd = $urandom();
            model(rwe, rf3, ra, rwd, xe, xl, xr, xw);
            apply($sformatf("rnd%0d", n), rwe, rf3, ra, rwd, xe, model_rd, xl, xr, xw);
        end
        check_memory("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory initiator for the multicycle RV32I core. It turns one CPU load/store request (byte address, funct3, store data) into accesses on the single-port word memory's active-low read/write strobes. Sub-word stores use read-modify-write. Loads return the selected lane, sign- or zero-extended. The unit sits between the control FSM/datapath and the 2^WORDS x 32 BRAM.

## Interface
Parameters:
- WORDS, 10, memory word-address width (2^WORDS words)
- DATA_WIDTH, 32, word width; only 32 is supported

Ports:
- clk_i  in  1  pos-edge clock
- reset_i  in  1  synchronous, active-high reset
- req_i  in  1  request valid; accepted when req_i & ready_o
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I funct3 (size/sign)
- addr_i  in  32  byte address
- wdata_i  in  32  store data (low lanes used for SB/SH)
- ready_o  out  1  unit idle and able to accept a request
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; misaligned address or illegal funct3
- rdata_o  out  32  load result, valid with done_o, held until the next load completes
- mem_addr_o  out  WORDS  word address to memory
- mem_data_o  out  32  write data to memory
- mem_wr_o  out  1  write strobe, active low
- mem_rd_o  out  1  read strobe, active low
- mem_data_i  in  32  memory read data, valid the cycle after mem_rd_o is low at a clock edge

## Operation
- FSM states: IDLE, RD, CAP, WR.
- ready_o = (state == IDLE).
- On acceptance, latch we_i, funct3_i, addr_i[1:0] and wdata_i. Set mem_addr_o <= addr_i[WORDS+1:2]. Higher address bits are ignored, so addresses wrap modulo 2^WORDS words.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Illegal or misaligned request: stay in IDLE and register done_o=1, err_o=1. No memory strobe. rdata_o is unchanged.
- Legal transitions out of IDLE:
  - Load → RD.
  - SW → WR, with mem_data_o <= wdata_i.
  - SB/SH → RD.
- RD: mem_rd_o=0, then go to CAP.
- CAP: mem_data_i is valid in this state.
  - Load: extract the little-endian lane (byte k = bits 8k+7:8k, k = addr[1:0]; halfword at addr[1]), extend it, register rdata_o, register done_o=1, err_o=0, then go to IDLE.
  - Sub-word store: merge the wdata_i low byte/halfword into the lane of mem_data_i, register the result into mem_data_o, then go to WR.
- WR: mem_wr_o=0; register done_o=1, err_o=0; then go to IDLE.
- Strobes are decoded from state and gated by ~reset_i. No memory write or read is issued at an edge where reset_i=1.
- A request presented while ready_o=0 is ignored, not queued.

## Timing
Cycle 0 is the acceptance edge.
- Load: RD in cycle 1, CAP in cycle 2, done_o and rdata_o in cycle 3. ready_o is high again in cycle 3.
- SW: WR in cycle 1, done_o in cycle 2.
- SB/SH: RD cycle 1, CAP cycle 2, WR cycle 3, done_o cycle 4.
- Error: done_o and err_o in cycle 1.
- A new request may be accepted in the same cycle done_o is high (back-to-back).
- Reset values: state IDLE; ready_o=1 once reset deasserts; done_o=0; err_o=0; rdata_o=0; mem_addr_o=0; mem_data_o=0; mem_rd_o=1; mem_wr_o=1.
- Reset mid-operation: the FSM returns to IDLE, no done_o pulse is produced for the aborted request, and a pending RMW write is discarded.

## Structure
- Package lsu_pkg holds:
  - the state enum (IDLE, RD, CAP, WR),
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU),
  - functions lane_extract(word, off, funct3) and lane_merge(word, wdata, off, funct3).
- One natural sub-module: lsu_align, combinational extract/merge plus legality/misalignment check, instantiated once.

## Test plan
- Memory word 3 = 0x55AA3312: LB at 0x0D → rdata_o = 0x00000033 in cycle 3; LW at 0x0C → 0x55AA3312; LHU at 0x0E → 0x000055AA.
- Word 14 = 0xBBAA1136: LB at 0x3B → 0xFFFFFFBB; LBU at 0x3B → 0x000000BB; LH at 0x3A → 0xFFFFBBAA.
- SB at 0x39 with wdata 0x123456EE on word 14 = 0xBBAA1136:
  - One mem_rd_o and one mem_wr_o pulse.
  - Word becomes 0xBBAAEE36; done_o in cycle 4.
  - Subsequent LW reads back 0xBBAAEE36.
- LH at 0x0D, SW at 0x0E, funct3=011: each gives done_o=err_o=1 in cycle 1, no strobe low, memory unchanged.
- Other cases:
  - Addr 0x00001004 with WORDS=10 accesses word 1 (wrap).
  - Reset asserted during WR: mem_wr_o stays 1, target word unchanged, no done_o, ready_o=1 after reset.
